// File: rtl/key_event_filter.sv
// key_event_filter: per-channel synchronised, debounced key front end with press/release/long/repeat pulses
module key_event_filter #(
  parameter int N_KEYS      = 4,
  parameter int I_CLK_FREQ  = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_key_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);
  localparam int DB_CYC     = I_CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC   = I_CLK_FREQ / 1000 * LONG_MS;
  localparam int REPEAT_CYC = I_CLK_FREQ / 1000 * REPEAT_MS;
  // repeat counter keeps a legal width even when repeat is disabled
  localparam int RC  = (REPEAT_CYC > 0) ? REPEAT_CYC : 1;
  localparam int DBW = $clog2(DB_CYC + 1);
  localparam int HW  = $clog2(LONG_CYC + 1);
  localparam int RW  = $clog2(RC + 1);
  localparam logic AL = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB} state_t;

  logic [N_KEYS-1:0] sync0, sync1;

  // two-stage synchroniser, parked at the inactive key level in reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync0 <= {N_KEYS{AL}};
      sync1 <= {N_KEYS{AL}};
    end else begin
      sync0 <= i_key;
      sync1 <= sync0;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    state_t         state, state_nxt;
    logic [DBW-1:0] db, db_nxt;
    logic [HW-1:0]  hold, hold_nxt;
    logic [RW-1:0]  rep, rep_nxt;
    logic           done, done_nxt;
    logic           lvl, lvl_nxt, prs, prs_nxt, rls, rls_nxt, lng, lng_nxt, rpt, rpt_nxt;
    logic           pressed;

    assign pressed = sync1[g] ^ AL;

    // next-state and event decode; counters freeze in states that do not touch them
    always_comb begin
      state_nxt = state;
      db_nxt    = db;
      hold_nxt  = hold;
      rep_nxt   = rep;
      done_nxt  = done;
      lvl_nxt   = lvl;
      prs_nxt   = 1'b0;
      rls_nxt   = 1'b0;
      lng_nxt   = 1'b0;
      rpt_nxt   = 1'b0;
      case (state)
        S_IDLE: if (pressed) begin
          state_nxt = S_PRESS_DB;
          db_nxt    = '0;
        end
        S_PRESS_DB:
          if (!pressed) state_nxt = S_IDLE;
          else if (db == DBW'(DB_CYC - 1)) begin
            state_nxt = S_HELD;
            prs_nxt   = 1'b1;
            lvl_nxt   = 1'b1;
            hold_nxt  = '0;
            rep_nxt   = '0;
            done_nxt  = 1'b0;
          end else db_nxt = db + DBW'(1);
        S_HELD:
          if (!pressed) begin
            state_nxt = S_RELEASE_DB;
            db_nxt    = '0;
          end else if (!done) begin
            if (hold == HW'(LONG_CYC - 1)) begin
              lng_nxt  = 1'b1;
              done_nxt = 1'b1;
            end else hold_nxt = hold + HW'(1);
          end else if (REPEAT_CYC > 0) begin
            if (rep == RW'(RC - 1)) begin
              rpt_nxt = 1'b1;
              rep_nxt = '0;
            end else rep_nxt = rep + RW'(1);
          end
        S_RELEASE_DB:
          if (pressed) state_nxt = S_HELD;
          else if (db == DBW'(DB_CYC - 1)) begin
            state_nxt = S_IDLE;
            rls_nxt   = 1'b1;
            lvl_nxt   = 1'b0;
          end else db_nxt = db + DBW'(1);
        default: state_nxt = S_IDLE;
      endcase
    end

    // channel state and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= S_IDLE;
        db    <= '0;
        hold  <= '0;
        rep   <= '0;
        done  <= 1'b0;
        lvl   <= 1'b0;
        prs   <= 1'b0;
        rls   <= 1'b0;
        lng   <= 1'b0;
        rpt   <= 1'b0;
      end else begin
        state <= state_nxt;
        db    <= db_nxt;
        hold  <= hold_nxt;
        rep   <= rep_nxt;
        done  <= done_nxt;
        lvl   <= lvl_nxt;
        prs   <= prs_nxt;
        rls   <= rls_nxt;
        lng   <= lng_nxt;
        rpt   <= rpt_nxt;
      end
    end

    assign o_key_level[g] = lvl;
    assign o_press[g]     = prs;
    assign o_release[g]   = rls;
    assign o_long[g]      = lng;
    assign o_repeat[g]    = rpt;
  end
endmodule

// File: tb/tb_key_event_filter.sv
// tb_key_event_filter: scoreboard bench for key_event_filter at 1 cycle = 1 ms
module tb_key_event_filter;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_key = 4'hF;
  logic [3:0] o_key_level, o_press, o_release, o_long, o_repeat;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         q[$];

  key_event_filter #(
    .N_KEYS(4), .I_CLK_FREQ(1000), .DEBOUNCE_MS(20), .LONG_MS(1000), .REPEAT_MS(200), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key(i_key), .o_key_level(o_key_level),
    .o_press(o_press), .o_release(o_release), .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 i_clk = ~i_clk;

  // absolute edge counter: after edge n, cyc == n
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // event code: cycle*64 + channel*8 + kind (0 press, 1 release, 2 long, 3 repeat)
  task automatic expect_ev(input int ch, input int kind, input int at);
    q.push_back(at * 64 + ch * 8 + kind);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // every output pulse is matched against the next expected event
  always @(negedge i_clk) begin
    logic [3:0] v;
    int code;
    if (i_rst_n)
      for (int k = 0; k < 4; k++) begin
        v = (k == 0) ? o_press : (k == 1) ? o_release : (k == 2) ? o_long : o_repeat;
        for (int ch = 0; ch < 4; ch++)
          if (v[ch]) begin
            code = cyc * 64 + ch * 8 + k;
            if (q.size() > 0) check("event", code, q.pop_front());
            else check("unexpected_event", code, 0);
          end
      end
  end

  initial begin
    int e, d;
    step(3);
    check("rst_level", o_key_level, 0);
    check("rst_press", o_press, 0);
    check("rst_release", o_release, 0);
    check("rst_long", o_long, 0);
    check("rst_repeat", o_repeat, 0);
    i_rst_n = 1'b1;
    step(5);
    // clean press and release on ch0
    e = cyc; i_key[0] = 1'b0; expect_ev(0, 0, e + 23);
    step(22); check("lvl0_before", o_key_level[0], 0);
    step(1);  check("lvl0_after", o_key_level[0], 1);
    step(77);
    e = cyc; i_key[0] = 1'b1; expect_ev(0, 1, e + 23);
    step(22); check("lvl0_held", o_key_level[0], 1);
    step(1);  check("lvl0_released", o_key_level[0], 0);
    step(10);
    // bouncing press on ch0
    for (int i = 0; i < 3; i++) begin
      i_key[0] = 1'b0; step(3);
      i_key[0] = 1'b1; step(2);
    end
    e = cyc; i_key[0] = 1'b0; expect_ev(0, 0, e + 23);
    step(100);
    e = cyc; i_key[0] = 1'b1; expect_ev(0, 1, e + 23);
    step(40);
    // long hold with repeats on ch1
    e = cyc; i_key[1] = 1'b0;
    expect_ev(1, 0, e + 23); expect_ev(1, 2, e + 1023);
    expect_ev(1, 3, e + 1223); expect_ev(1, 3, e + 1423);
    step(1500);
    e = cyc; i_key[1] = 1'b1; expect_ev(1, 1, e + 23);
    step(40);
    // 10-cycle release glitch on ch2 delays o_long by 11 edges
    e = cyc; i_key[2] = 1'b0;
    expect_ev(2, 0, e + 23); expect_ev(2, 2, e + 1034);
    step(200); i_key[2] = 1'b1;
    step(10);  i_key[2] = 1'b0;
    step(890);
    d = cyc; i_key[2] = 1'b1; expect_ev(2, 1, d + 23);
    step(40);
    // all keys together, then reset mid-hold
    e = cyc; i_key = 4'h0;
    for (int ch = 0; ch < 4; ch++) expect_ev(ch, 0, e + 23);
    step(23); check("press_all", o_press, 4'hF);
    step(27); i_rst_n = 1'b0; #1;
    check("midrst_level", o_key_level, 0);
    check("midrst_release", o_release, 0);
    step(3); i_rst_n = 1'b1;
    d = cyc;
    for (int ch = 0; ch < 4; ch++) expect_ev(ch, 0, d + 23);
    step(60); check("lvl_all", o_key_level, 4'hF);
    e = cyc; i_key = 4'hF;
    for (int ch = 0; ch < 4; ch++) expect_ev(ch, 1, e + 23);
    step(40);
    check("pending_events", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
